// File: rtl/ber_checker_mc.sv
// ber_checker_mc: multi-lane self-synchronising PRBS bit-error-rate checker with snapshot readout
module ber_checker_mc #(
  parameter int N_CH       = 2,
  parameter int PRBS_ORDER = 9,
  parameter int VERIFY_LEN = 64,
  parameter int WIN_LEN    = 1024,
  parameter int ERR_THR    = 32,
  parameter int CNT_W      = 48,
  parameter int LOL_W      = 16
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [N_CH-1:0]  i_rx_bits,
  input  logic             i_clear,
  input  logic             i_snapshot,
  input  logic [3:0]       i_ch_sel,
  output logic [N_CH-1:0]  o_lock,
  output logic [N_CH-1:0]  o_ber_ok_led,
  output logic             o_snap_valid,
  output logic [CNT_W-1:0] o_snap_bits,
  output logic [CNT_W-1:0] o_snap_errs,
  output logic [LOL_W-1:0] o_snap_lol
);
  localparam int P  = PRBS_ORDER;
  localparam int T  = (P == 7) ? 6 : (P == 9) ? 5 : (P == 15) ? 14 : 1;
  localparam int PW = $clog2(((P > VERIFY_LEN) ? P : VERIFY_LEN) + 1);
  localparam int WW = $clog2(WIN_LEN + 1);
  localparam int EW = $clog2(ERR_THR + 2);
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;
  if (P != 7 && P != 9 && P != 15) begin : g_bad_order
    $error("ber_checker_mc: PRBS_ORDER must be 7, 9 or 15");
  end
  logic [CNT_W-1:0] bits_a [N_CH];
  logic [CNT_W-1:0] errs_a [N_CH];
  logic [LOL_W-1:0] lol_a  [N_CH];
  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    state_t           state;
    logic [P-1:0]     lfsr;
    logic [PW-1:0]    cnt;
    logic [WW-1:0]    win_cnt;
    logic [EW-1:0]    win_errs;
    logic [EW-1:0]    win_next;
    logic [CNT_W-1:0] bits;
    logic [CNT_W-1:0] errs;
    logic [LOL_W-1:0] lol;
    logic             lock;
    logic             ok;
    logic             rx;
    logic             pred;
    logic             err;
    logic             lost;
    logic             wend;
    assign rx       = i_rx_bits[g];
    assign pred     = lfsr[P-1] ^ lfsr[T-1];
    assign err      = rx ^ pred;
    assign win_next = win_errs + EW'(err);
    assign lost     = state == LOCKED && win_next > EW'(ERR_THR);
    assign wend     = win_cnt == WW'(WIN_LEN - 1);
    // Lane lock FSM, LFSR (fed back from itself once locked) and saturating statistics
    always_ff @(posedge clk) begin
      if (i_reset) begin
        state    <= SEARCH;
        lfsr     <= '0;
        cnt      <= '0;
        win_cnt  <= '0;
        win_errs <= '0;
        bits     <= '0;
        errs     <= '0;
        lol      <= '0;
        lock     <= 1'b0;
        ok       <= 1'b0;
      end else begin
        if (i_en) begin
          lfsr <= {lfsr[P-2:0], state == LOCKED ? pred : rx};
          case (state)
            SEARCH: begin
              cnt <= cnt == PW'(P - 1) ? '0 : cnt + PW'(1);
              if (cnt == PW'(P - 1)) state <= VERIFY;
            end
            VERIFY: begin
              cnt <= (err || cnt == PW'(VERIFY_LEN - 1)) ? '0 : cnt + PW'(1);
              if (err) state <= SEARCH;
              else if (cnt == PW'(VERIFY_LEN - 1)) begin
                state <= LOCKED;
                lock  <= 1'b1;
              end
            end
            LOCKED: begin
              win_cnt  <= (lost || wend) ? '0 : win_cnt + WW'(1);
              win_errs <= (lost || wend) ? '0 : win_next;
              if (lost) begin
                state <= SEARCH;
                lock  <= 1'b0;
                ok    <= 1'b0;
              end else if (wend) ok <= win_next == '0;
            end
            default: state <= SEARCH;
          endcase
        end
        if (i_clear) begin
          bits <= '0;
          errs <= '0;
          lol  <= '0;
        end else if (i_en && state == LOCKED) begin
          bits <= &bits ? bits : bits + CNT_W'(1);
          errs <= (&errs || !err) ? errs : errs + CNT_W'(1);
          lol  <= (&lol || !lost) ? lol : lol + LOL_W'(1);
        end
      end
    end
    assign o_lock[g]       = lock;
    assign o_ber_ok_led[g] = ok;
    assign bits_a[g]       = bits;
    assign errs_a[g]       = errs;
    assign lol_a[g]        = lol;
  end
  logic [CNT_W-1:0] sel_bits;
  logic [CNT_W-1:0] sel_errs;
  logic [LOL_W-1:0] sel_lol;
  // Lane select for the snapshot; an index past the last lane reads as zeros
  always_comb begin
    sel_bits = '0;
    sel_errs = '0;
    sel_lol  = '0;
    for (int i = 0; i < N_CH; i++) begin
      sel_bits = i_ch_sel == 4'(i) ? bits_a[i] : sel_bits;
      sel_errs = i_ch_sel == 4'(i) ? errs_a[i] : sel_errs;
      sel_lol  = i_ch_sel == 4'(i) ? lol_a[i]  : sel_lol;
    end
  end
  // Snapshot capture of pre-clear counter values, with a one-cycle valid pulse
  always_ff @(posedge clk) begin
    if (i_reset) begin
      o_snap_valid <= 1'b0;
      o_snap_bits  <= '0;
      o_snap_errs  <= '0;
      o_snap_lol   <= '0;
    end else begin
      o_snap_valid <= i_snapshot;
      if (i_snapshot) begin
        o_snap_bits <= sel_bits;
        o_snap_errs <= sel_errs;
        o_snap_lol  <= sel_lol;
      end
    end
  end
endmodule

// File: tb/tb_ber_checker_mc.sv
// tb_ber_checker_mc: randomized and directed checks of ber_checker_mc against a queue-based reference model
module tb_ber_checker_mc;
  localparam int NL = 2, P = 9, T = 5, VL = 64, WL = 1024, THR = 32;
  localparam longint SATC = (64'd1 << 48) - 1, SATL = 65535;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, en = 1'b0, clr = 1'b0, snap = 1'b0;
  logic [NL-1:0] rx = '0;
  logic [3:0] sel = '0;
  logic [NL-1:0] lock, led;
  logic sv;
  logic [47:0] sb, se;
  logic [15:0] sl;
  logic rst8 = 1'b1, en8 = 1'b0, rx8 = 1'b0, snap8 = 1'b0;
  logic lock8, led8, sv8;
  logic [7:0] sb8, se8;
  logic [15:0] sl8;
  ber_checker_mc dut (
    .clk(clk), .i_reset(rst), .i_en(en), .i_rx_bits(rx), .i_clear(clr), .i_snapshot(snap),
    .i_ch_sel(sel), .o_lock(lock), .o_ber_ok_led(led), .o_snap_valid(sv), .o_snap_bits(sb),
    .o_snap_errs(se), .o_snap_lol(sl)
  );
  ber_checker_mc #(.N_CH(1), .CNT_W(8)) dut8 (
    .clk(clk), .i_reset(rst8), .i_en(en8), .i_rx_bits(rx8), .i_clear(1'b0), .i_snapshot(snap8),
    .i_ch_sel(4'd0), .o_lock(lock8), .o_ber_ok_led(led8), .o_snap_valid(sv8), .o_snap_bits(sb8),
    .o_snap_errs(se8), .o_snap_lol(sl8)
  );
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // PRBS sources: bit history per stream, b[n] = b[n-P] ^ b[n-T]
  bit gh [3][$];
  function automatic bit gen(input int l);
    bit b;
    b = gh[l][0] ^ gh[l][P-T];
    gh[l].push_back(b);
    void'(gh[l].pop_front());
    return b;
  endfunction
  // Reference model: mode 0 search, 1 verify, 2 locked; mh holds the last P bits the checker has seen
  int md [NL], ph [NL], wn [NL], we [NL];
  bit mh [NL][$];
  longint mb [NL], me [NL], ml [NL];
  bit mlock [NL], mok [NL];
  bit m_sv;
  longint m_sb, m_se, m_sl;
  task automatic m_reset();
    for (int l = 0; l < NL; l++) begin
      md[l] = 0; ph[l] = 0; wn[l] = 0; we[l] = 0;
      mb[l] = 0; me[l] = 0; ml[l] = 0; mlock[l] = 0; mok[l] = 0;
      mh[l].delete();
      repeat (P) mh[l].push_back(1'b0);
    end
    m_sv = 0; m_sb = 0; m_se = 0; m_sl = 0;
  endtask
  task automatic m_step();
    bit r, p, e;
    m_sv = snap;
    if (snap) begin
      if (int'(sel) < NL) begin
        m_sb = mb[sel]; m_se = me[sel]; m_sl = ml[sel];
      end else begin
        m_sb = 0; m_se = 0; m_sl = 0;
      end
    end
    for (int l = 0; l < NL; l++) begin
      if (en) begin
        r = rx[l];
        p = mh[l][0] ^ mh[l][P-T];
        e = r ^ p;
        if (md[l] == 2) begin
          mh[l].push_back(p);
          wn[l]++;
          we[l] += int'(e);
          if (!clr) begin
            if (mb[l] < SATC) mb[l]++;
            if (e && me[l] < SATC) me[l]++;
          end
          if (we[l] > THR) begin
            md[l] = 0; ph[l] = 0; mlock[l] = 0; mok[l] = 0; wn[l] = 0; we[l] = 0;
            if (!clr && ml[l] < SATL) ml[l]++;
          end else if (wn[l] == WL) begin
            mok[l] = we[l] == 0; wn[l] = 0; we[l] = 0;
          end
        end else begin
          mh[l].push_back(r);
          if (md[l] == 1 && e) begin
            md[l] = 0; ph[l] = 0;
          end else begin
            ph[l]++;
            if (md[l] == 0 && ph[l] == P) begin
              md[l] = 1; ph[l] = 0;
            end else if (md[l] == 1 && ph[l] == VL) begin
              md[l] = 2; ph[l] = 0; mlock[l] = 1;
            end
          end
        end
        void'(mh[l].pop_front());
      end
      if (clr) begin
        mb[l] = 0; me[l] = 0; ml[l] = 0;
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    if (rst) m_reset(); else m_step();
    #1;
    chk("lock", lock, {mlock[1], mlock[0]});
    chk("led", led, {mok[1], mok[0]});
    chk("snap", {sv, sb, se, sl}, {m_sv, m_sb[47:0], m_se[47:0], m_sl[15:0]});
  endtask
  task automatic step(input bit e, input logic [NL-1:0] r, input bit c, input bit s, input logic [3:0] ch);
    en = e; rx = r; clr = c; snap = s; sel = ch;
    tick();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step(0, '0, 0, 0, 0);
    rst = 1'b0;
  endtask
  int n;
  bit b0, b1;
  initial begin
    logic [8:0] s0, s1, s2;
    s0 = 9'h1AA; s1 = 9'h0F3; s2 = 9'h155;
    for (int i = 0; i < P; i++) begin
      gh[0].push_back(s0[i]); gh[1].push_back(s1[i]); gh[2].push_back(s2[i]);
    end
    m_reset();
    do_reset();
    chk("reset_outputs", {lock, led, sv, sb, se, sl}, '0);
    n = 0;
    do begin
      b0 = gen(0); b1 = gen(1);
      step(1, {b1, b0}, 0, 0, 0);
      n++;
    end while (!lock[0] && n < 300);
    chk("lock_latency", n, 73);
    n = 0;
    while (!led[0] && n < 2000) begin
      b0 = gen(0); b1 = gen(1);
      step(1, {b1, b0}, 0, 0, 0);
      n++;
    end
    chk("ok_led_latency", n, 1024);
    step(0, '0, 0, 1, 0);
    chk("ideal_bits", sb, 1024);
    chk("ideal_errs", se, 0);
    step(0, '0, 1, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      b0 = gen(0); b1 = gen(1) ^ (i % 100 == 50);
      step(1, {b1, b0}, 0, 0, 0);
    end
    step(0, '0, 0, 1, 1);
    chk("flip_bits", sb, 2000);
    chk("flip_errs", se, 20);
    chk("flip_lol", sl, 0);
    chk("flip_lock_held", lock[1], 1);
    chk("flip_led_off", led[1], 0);
    n = 0;
    while (lock[0] && n < 1000) begin
      b0 = 1'($urandom_range(0, 1)); b1 = gen(1);
      step(1, {b1, b0}, 0, 0, 0);
      n++;
    end
    chk("random_drops_lock", lock[0], 0);
    step(0, '0, 0, 1, 0);
    chk("random_lol", sl, 1);
    n = 0;
    while (!lock[0] && n < 500) begin
      b0 = gen(0); b1 = gen(1);
      step(1, {b1, b0}, 0, 0, 0);
      n++;
    end
    chk("relock", lock[0], 1);
    chk("relock_led_off", led[0], 0);
    do_reset();
    n = 0;
    while (!lock[0] && n < 400) begin
      if (n % 4 == 3) begin
        b0 = gen(0); b1 = gen(1);
        step(1, {b1, b0}, 0, 0, 0);
      end else step(0, '0, 0, 0, 0);
      n++;
    end
    chk("duty_latency", (n >= 289 && n <= 295), 1);
    step(0, '0, 1, 0, 0);
    for (int i = 0; i < 500; i++) begin
      b0 = gen(0); b1 = gen(1);
      step(1, {b1, b0}, 0, 0, 0);
    end
    step(0, '0, 1, 1, 0);
    chk("snap_clear_bits", sb, 500);
    step(0, '0, 0, 1, 0);
    chk("post_clear_bits", sb, 0);
    step(0, '0, 0, 1, 5);
    chk("oob_sel", {sv, sb, se, sl}, {1'b1, 112'b0});
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        b0 = gen(0) ^ (i >= 1500 && $urandom_range(0, 5) == 0);
        b1 = gen(1) ^ ($urandom_range(0, 63) == 0);
        step(1, {b1, b0}, $urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0, 4'($urandom_range(0, 3)));
      end else step(0, 2'($urandom_range(0, 3)), 0, $urandom_range(0, 19) == 0, 4'($urandom_range(0, 3)));
    end
    rst8 = 1'b0; en8 = 1'b1;
    for (int i = 0; i < 373; i++) begin
      rx8 = gen(2);
      step(0, '0, 0, 0, 0);
      if (i == 72) chk("lock8_latency", lock8, 1);
    end
    en8 = 1'b0; snap8 = 1'b1;
    step(0, '0, 0, 0, 0);
    snap8 = 1'b0;
    chk("sat_valid", sv8, 1);
    chk("sat_bits", sb8, 255);
    do_reset();
    for (int i = 0; i < 80; i++) begin
      b0 = gen(0); b1 = gen(1);
      step(1, {b1, b0}, 0, 0, 0);
    end
    chk("pre_reset_lock", lock, 2'b11);
    rst = 1'b1;
    b0 = gen(0); b1 = gen(1);
    step(1, {b1, b0}, 0, 1, 0);
    rst = 1'b0;
    chk("mid_reset_outputs", {lock, led, sv, sb, se, sl}, '0);
    step(0, '0, 0, 0, 0);
    chk("mid_reset_no_snap", sv, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
